// File: rtl/spi_rx_pkg.sv
// Shared constants, the FIFO entry layout and a FIFO count-width helper for
// the SPI receive front end.
package spi_rx_pkg;

  localparam int SPI_BITS_PER_BYTE = 8;
  localparam int BIT_CNT_W         = $clog2(SPI_BITS_PER_BYTE);

  // FIFO entry when the first-byte flag travels with the data.
  typedef struct packed {
    logic                         first;
    logic [SPI_BITS_PER_BYTE-1:0] data;
  } rx_entry_t;

  // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_rx_frontend_if.sv
// Byte stream from the SPI front end to the video/command processor.
interface spi_rx_frontend_if;
  import spi_rx_pkg::*;

  logic [SPI_BITS_PER_BYTE-1:0] rx_data;
  logic                         rx_first;
  logic                         rx_valid;
  logic                         rx_ready;

  // Transfer happens on a clock where rx_valid && rx_ready; while rx_valid is
  // high and rx_ready low, rx_data/rx_first hold steady and rx_valid stays up.
  modport master (output rx_data, output rx_first, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_first, input rx_valid, output rx_ready);

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO with a registered head output: a push into an empty FIFO
// becomes visible on the following cycle, never bypassed.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [WIDTH-1:0]                 head,
  output logic                             full,
  output logic                             empty,
  output logic [fifo_count_w(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_count_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_next;

      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Keep head equal to the entry that will sit at rd_ptr after this edge.
      if (do_pop) begin
        if (count == CW'(1)) begin
          if (do_push) head <= push_data;
        end else begin
          head <= mem[rd_next];
        end
      end else if (empty && do_push) begin
        head <= push_data;
      end
    end
  end

endmodule

// File: rtl/spi_rx_frontend.sv
// SPI mode-0 slave receive front end: oversampled SCK/MOSI/CS, byte
// deserializer, receive FIFO and status byte on MISO. Optional macro
// SPI_RX_FIRST_FLAG_EN carries a first-byte-of-frame flag through the FIFO.
module spi_rx_frontend
  import spi_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                spi_sck,
  input  logic                spi_mosi,
  input  logic                spi_cs,
  output logic                spi_miso,
  input  logic [7:0]          status_in,
  spi_rx_frontend_if.master   rx,
  output logic                overflow,
  input  logic                overflow_clear,
  output logic                busy,
  input  logic                clock,
  input  logic                reset_n
);

  localparam int CW = fifo_count_w(FIFO_DEPTH);
`ifdef SPI_RX_FIRST_FLAG_EN
  localparam int ENTRY_W = $bits(rx_entry_t);
`else
  localparam int ENTRY_W = SPI_BITS_PER_BYTE;
`endif

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;

  // Sync chains reset low so that a CS already low at reset release is not
  // mistaken for a fresh frame start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;

  logic                         active;
  logic [BIT_CNT_W-1:0]         bit_cnt;
  logic [SPI_BITS_PER_BYTE-1:0] mosi_sr;
  logic [SPI_BITS_PER_BYTE-1:0] miso_sr;
  logic [SPI_BITS_PER_BYTE-1:0] next_byte;
  logic                         push_q;
  logic [ENTRY_W-1:0]           push_data_q;
`ifdef SPI_RX_FIRST_FLAG_EN
  logic                         first_lat;
`endif

  assign next_byte = {mosi_sr[SPI_BITS_PER_BYTE-2:0], mosi_s};

  // active: a CS falling edge has been seen and CS is still low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active      <= 1'b0;
      bit_cnt     <= '0;
      mosi_sr     <= '0;
      miso_sr     <= '0;
      spi_miso    <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
`ifdef SPI_RX_FIRST_FLAG_EN
      first_lat   <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      if (cs_fall) begin
        active   <= 1'b1;
        bit_cnt  <= '0;
        miso_sr  <= status_in;
        spi_miso <= status_in[7];
`ifdef SPI_RX_FIRST_FLAG_EN
        first_lat <= 1'b1;
`endif
      end else if (cs_s) begin
        active  <= 1'b0;
        bit_cnt <= '0;
      end else if (active) begin
        if (sck_rise) begin
          mosi_sr <= next_byte;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_CNT_W'(SPI_BITS_PER_BYTE - 1)) begin
            push_q <= 1'b1;
`ifdef SPI_RX_FIRST_FLAG_EN
            push_data_q <= {first_lat, next_byte};
            first_lat   <= 1'b0;
`else
            push_data_q <= next_byte;
`endif
          end
        end
        // Zero fill means MISO idles at 0 once the status byte is out.
        if (sck_fall) begin
          miso_sr  <= {miso_sr[SPI_BITS_PER_BYTE-2:0], 1'b0};
          spi_miso <= miso_sr[SPI_BITS_PER_BYTE-2];
        end
      end
    end
  end

  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               pop;

  assign pop = rx.rx_valid && rx.rx_ready;

  spi_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end else if (push_q && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  assign rx.rx_valid = ~fifo_empty;
  assign busy        = active | (fifo_count != '0);

`ifdef SPI_RX_FIRST_FLAG_EN
  rx_entry_t head_entry;
  assign head_entry  = head;
  assign rx.rx_data  = head_entry.data;
  assign rx.rx_first = head_entry.first;
`else
  assign rx.rx_data  = head;
  assign rx.rx_first = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Directed and randomized frames for spi_rx_frontend, checked against a
// frame-level queue model of received bytes, MISO content and overflow.
module tb_spi_rx_frontend;

  localparam int DEPTH = 16;
  localparam int SYNC  = 2;
`ifdef SPI_RX_FIRST_FLAG_EN
  localparam bit FIRST_EN = 1'b1;
`else
  localparam bit FIRST_EN = 1'b0;
`endif

  // clock / reset
  logic       clock = 1'b0;
  logic       reset_n;
  logic       spi_sck, spi_mosi, spi_cs, spi_miso;
  logic [7:0] status_in;
  logic       overflow, overflow_clear, busy;

  always #5 clock = ~clock;

  spi_rx_frontend_if rx_if ();

  spi_rx_frontend #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .spi_sck        (spi_sck),
    .spi_mosi       (spi_mosi),
    .spi_cs         (spi_cs),
    .spi_miso       (spi_miso),
    .status_in      (status_in),
    .rx             (rx_if.master),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .busy           (busy),
    .clock          (clock),
    .reset_n        (reset_n)
  );

  // scoreboard / model state
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  bit         model_ovf;
  bit         model_first;
  int         model_idx;
  logic [7:0] model_status;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // One SPI bit as a mode-0 master: MOSI set, MISO sampled at the rising edge.
  // mode 1 checks push latency, mode 2 pulses rx_ready on the push cycle.
  task automatic spi_bit(input logic b, input int mode, output logic mbit);
    spi_mosi = b;
    tick(4);
    mbit    = spi_miso;
    spi_sck = 1'b1;
    if (mode == 1) begin
      repeat (SYNC + 1) @(posedge clock);
      @(negedge clock);
      check("latency_early", rx_if.rx_valid, 32'd0);
      @(posedge clock);
      @(negedge clock);
      check("latency_valid", rx_if.rx_valid, 32'd1);
    end else if (mode == 2) begin
      repeat (SYNC + 1) @(posedge clock);
      #2 rx_if.rx_ready = 1'b1;
      @(posedge clock);
      #2 rx_if.rx_ready = 1'b0;
    end else begin
      tick(4);
    end
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    logic [7:0] got;
    logic       mb;
    logic [7:0] exp_miso;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(b[i], (i == 0) ? mode : 0, mb);
      got[i] = mb;
    end
    exp_miso = (model_idx == 0) ? model_status : 8'h00;
    check("miso_byte", {24'd0, got}, {24'd0, exp_miso});
    if (mode == 2) void'(exp_q.pop_front());
    if (exp_q.size() < DEPTH) exp_q.push_back({model_first, b});
    else model_ovf = 1'b1;
    model_first = 1'b0;
    model_idx++;
  endtask

  task automatic frame_start(input logic [7:0] st);
    status_in    = st;
    model_status = st;
    model_first  = 1'b1;
    model_idx    = 0;
    spi_cs       = 1'b0;
    tick(8);
  endtask

  task automatic frame_end();
    tick(4);
    spi_cs = 1'b1;
    tick(8);
  endtask

  task automatic drain(input string tag);
    logic [8:0] e;
    int         n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      @(negedge clock);
      check({tag, "_valid"}, rx_if.rx_valid, 32'd1);
      check({tag, "_data"}, rx_if.rx_data, e[7:0]);
      check({tag, "_first"}, rx_if.rx_first, FIRST_EN ? e[8] : 1'b0);
      rx_if.rx_ready = 1'b1;
      @(posedge clock);
      #2 rx_if.rx_ready = 1'b0;
    end
    @(negedge clock);
    check({tag, "_empty"}, rx_if.rx_valid, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    logic mb;
    int   nb;
    reset_n        = 1'b0;
    spi_sck        = 1'b0;
    spi_mosi       = 1'b0;
    spi_cs         = 1'b1;
    status_in      = 8'h00;
    overflow_clear = 1'b0;
    rx_if.rx_ready = 1'b0;
    model_ovf      = 1'b0;
    model_first    = 1'b0;
    model_idx      = 0;
    model_status   = 8'h00;
    tick(3);
    @(negedge clock);
    check("rst_miso", spi_miso, 32'd0);
    check("rst_valid", rx_if.rx_valid, 32'd0);
    check("rst_data", rx_if.rx_data, 32'd0);
    check("rst_first", rx_if.rx_first, 32'd0);
    check("rst_overflow", overflow, 32'd0);
    check("rst_busy", busy, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    tick(4);

    // single byte with latency check
    frame_start(8'h3C);
    @(negedge clock);
    check("single_busy", busy, 32'd1);
    send_byte(8'hA5, 1);
    frame_end();
    @(negedge clock);
    check("single_overflow", overflow, {31'd0, model_ovf});
    drain("single");
    check("idle_busy", busy, 32'd0);

    // multi-byte frame, head held stable while not ready
    frame_start(8'h96);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    frame_end();
    @(negedge clock);
    check("hold_data_a", rx_if.rx_data, exp_q[0][7:0]);
    tick(5);
    @(negedge clock);
    check("hold_data_b", rx_if.rx_data, exp_q[0][7:0]);
    drain("multi");

    // overflow: DEPTH+1 bytes with nobody reading
    frame_start(8'h5C);
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 0);
    frame_end();
    @(negedge clock);
    check("ovf_set", overflow, {31'd0, model_ovf});
    drain("ovf");
    check("ovf_sticky", overflow, {31'd0, model_ovf});
    @(negedge clock);
    overflow_clear = 1'b1;
    @(posedge clock);
    #2 overflow_clear = 1'b0;
    model_ovf = 1'b0;
    @(negedge clock);
    check("ovf_cleared", overflow, {31'd0, model_ovf});

    // full FIFO with a pop on the cycle the next byte lands
    frame_start(8'hC3);
    for (int i = 0; i < DEPTH; i++) send_byte(8'h20 + 8'(i), 0);
    send_byte(8'h30, 2);
    frame_end();
    @(negedge clock);
    check("fullpop_overflow", overflow, {31'd0, model_ovf});
    drain("fullpop");

    // aborted byte followed by a clean frame
    frame_start(8'hFF);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 0, mb);
    frame_end();
    frame_start(8'h12);
    send_byte(8'h5A, 0);
    frame_end();
    drain("abort");

    // reset in the middle of a frame
    frame_start(8'h44);
    send_byte(8'h11, 0);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, 0, mb);
    reset_n = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    tick(2);
    @(negedge clock);
    check("mid_rst_miso", spi_miso, 32'd0);
    check("mid_rst_valid", rx_if.rx_valid, 32'd0);
    check("mid_rst_data", rx_if.rx_data, 32'd0);
    check("mid_rst_first", rx_if.rx_first, 32'd0);
    check("mid_rst_overflow", overflow, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) spi_bit(1'b0, 0, mb);
    tick(8);
    @(negedge clock);
    check("post_rst_ignored", rx_if.rx_valid, 32'd0);
    check("post_rst_busy", busy, 32'd0);
    frame_end();
    frame_start(8'hA0);
    send_byte(8'h77, 0);
    frame_end();
    drain("after_rst");

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      nb = $urandom_range(1, 5);
      frame_start(8'($urandom_range(0, 255)));
      for (int b = 0; b < nb; b++) send_byte(8'($urandom_range(0, 255)), 0);
      frame_end();
      @(negedge clock);
      check("rand_overflow", overflow, {31'd0, model_ovf});
      drain("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_rx_frontend.md
Name: spi_rx_frontend

Overview:
- MCU-facing SPI slave front end that sits directly upstream of the video/command processor.
- Oversamples SPI SCK/MOSI/CS in the system `clock` domain and deserializes MOSI into bytes.
- Buffers the bytes in a small FIFO and presents them to the processor on a valid/ready stream.
- Shifts a status byte out on MISO during each transaction. The MISO tristate (enable = CS) remains in the top level.

Parameters:
- FIFO_DEPTH, 16, number of byte entries in the receive FIFO; must be a power of two and at least 2.
- SYNC_STAGES, 2, synchronizer flops on each of spi_sck, spi_mosi and spi_cs; must be at least 2.

Ports:
- clock  in  1  system clock; must be at least 4x the SCK frequency.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  SPI clock (mode 0), asynchronous to `clock`.
- spi_mosi  in  1  SPI data in, MSB first.
- spi_cs  in  1  chip select, active low.
- spi_miso  out  1  SPI data out, MSB first.
- status_in  in  8  status byte, snapshotted at the CS falling edge.
- rx_data  out  8  received byte at the FIFO head.
- rx_first  out  1  the head byte is the first byte after a CS falling edge.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte.
- overflow  out  1  sticky: a completed byte was dropped because the FIFO was full.
- overflow_clear  in  1  clears `overflow`.
- busy  out  1  CS is low (synchronized), or the FIFO is not empty.

Behaviour:
- Reset values:
  - `spi_miso` = 0; `rx_valid` = 0; `rx_data` = 0; `rx_first` = 0; `overflow` = 0; `busy` = 0.
  - FIFO empty, bit counter 0, shift registers 0.
- Synchronization: SCK, MOSI and CS each pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one further flop.
- Frame start (CS falling edge):
  - Bit counter := 0.
  - MISO shift register := `status_in`.
  - `spi_miso` := status_in[7] on the same cycle.
  - The first-flag latch := 1.
- SCK rising edge with CS low:
  - MOSI shift register := {mosi_sr[6:0], mosi_sync}; bit counter += 1.
  - On the 8th bit (counter wraps 7→0), the assembled byte and the first-flag latch are pushed into the FIFO, then the first-flag latch := 0.
- SCK falling edge with CS low:
  - The MISO shift register shifts left with 0 fill; `spi_miso` := the new bit 7.
  - After 8 bits, `spi_miso` drives 0 until the next CS falling edge.
- Push latency: the byte appears on `rx_data`/`rx_valid` SYNC_STAGES+2 clocks after the 8th SCK rising edge at the pin.
- CS rising edge mid-byte: the partial byte is discarded and the counter resets. The CS level gates everything; SCK edges while CS is high are ignored.
- FIFO:
  - Occupancy is tracked with a $clog2(FIFO_DEPTH)+1-bit count. Read and write pointers wrap modulo FIFO_DEPTH.
  - Pop occurs when rx_valid && rx_ready.
  - Push when full: the byte is dropped, the FIFO is unchanged, and `overflow` := 1 on the next cycle.
  - Push while full with a simultaneous pop: the push is accepted and no overflow is recorded.
  - Push while empty with rx_ready=1: the byte is not bypassed; it is visible one cycle later.
- `overflow`:
  - `overflow_clear` takes priority over a set in the same cycle.
  - It stays set until cleared.
- `rx_data`/`rx_first` are registered FIFO head outputs and remain stable while rx_valid && !rx_ready.
- Reset asserted mid-frame: all state clears immediately. After release, bytes are accepted only after a fresh CS falling edge. The "CS seen low" flag resets to 0.

Optional Feature:
- Macro: SPI_RX_FIRST_FLAG_EN.
- Defined: FIFO entries are 9 bits wide ({first, data}), and `rx_first` is valid as described above.
- Undefined: FIFO entries are 8 bits, `rx_first` is tied to 0, and the first-flag latch is not built.

Decomposition:
- Package spi_rx_pkg:
  - SPI_BITS_PER_BYTE = 8.
  - typedef rx_entry_t (packed struct {first, data[7:0]}, used under the macro).
  - FIFO count width function.
- Sub-module spi_rx_fifo: synchronous FIFO with parameterized depth/width, push/pop/full/empty/count, registered head output.
- The synchronizer is inline flops; it is not a separate module.

Test Plan:
- Single byte: CS low, send 0xA5 at SCK = clock/8, CS high.
  - rx_data = 0xA5, rx_first = 1, rx_valid pulses one entry, no overflow.
  - MISO captured on rising edges equals status_in = 0x3C.
- Multi-byte frame: send 0x01, 0x02, 0x03 in one CS frame with rx_ready held at 0, then pop.
  - Popped in order: 0x01 (first=1), 0x02 (first=0), 0x03 (first=0).
  - MISO carries the status byte, then 0x00 for bytes 2–3.
- Overflow: rx_ready = 0, send FIFO_DEPTH+1 = 17 bytes (0x00..0x10).
  - overflow = 1; FIFO holds 0x00..0x0F; 0x10 is lost.
  - Pulse overflow_clear → overflow = 0.
- Full with simultaneous pop: FIFO full, rx_ready = 1 on the cycle the 17th byte completes.
  - The byte is accepted, overflow stays 0, count stays 16.
- Aborted byte: CS rises after 5 bits of 0xFF, then a new frame sends 0x5A.
  - Only 0x5A is received, with first = 1.
- Reset mid-frame: assert reset_n = 0 after 3 bits, release, then send 0x77 in a new frame.
  - All outputs are 0 during reset; afterwards exactly one byte, 0x77, is received.
